// File: rtl/cpu_pkg.sv
// Purpose: shared CPU types and helpers for the HI/LO multiply/divide unit.
// Contents: op and state enums, iteration count, two's-complement negate.
package cpu_pkg;

    localparam int unsigned CPU_WIDTH    = 32;
    localparam int unsigned MULDIV_ITERS = CPU_WIDTH;
    localparam int unsigned CPU_DWIDTH   = 2 * CPU_WIDTH;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Modular two's-complement negate on a double-width value.
    function automatic logic [CPU_DWIDTH-1:0] neg2c(input logic [CPU_DWIDTH-1:0] x);
        return ~x + CPU_DWIDTH'(1);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Purpose: iterative magnitude datapath shared by multiply and divide.
// Ports: clk/rst, i_load (capture operands), i_step (one iteration),
//        i_is_div (select restoring divide vs shift-add multiply),
//        i_a/i_b operands, o_hi/o_lo raw accumulator halves.
// Multiply: {o_hi,o_lo} becomes a*b. Divide: o_hi = remainder, o_lo = quotient.
module muldiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_mul_t;
    logic [WIDTH:0]   w_div_r2;
    logic [WIDTH:0]   w_div_diff;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // One iteration: hi is the upper accumulator (mul) or partial remainder (div),
    // lo holds the multiplier bits being consumed (mul) or dividend/quotient (div).
    always_comb begin
        w_hi_nxt   = r_hi;
        w_lo_nxt   = r_lo;
        w_mul_sum  = {1'b0, r_hi} + {1'b0, r_opnd};
        w_mul_t    = r_lo[0] ? w_mul_sum : {1'b0, r_hi};
        w_div_r2   = {r_hi, r_lo[WIDTH-1]};
        w_div_diff = w_div_r2 - {1'b0, r_opnd};
        if (i_is_div) begin
            if (!w_div_diff[WIDTH]) begin
                w_hi_nxt = w_div_diff[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_div_r2[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add shifts into hi's MSB.
            w_hi_nxt = w_mul_t[WIDTH:1];
            w_lo_nxt = {w_mul_t[0], r_lo[WIDTH-1:1]};
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_hi   <= '0;
            r_lo   <= i_a;
            r_opnd <= i_b;
        end else if (i_step) begin
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Purpose: MIPS HI/LO multiply/divide sequencer; owns HI and LO.
// Ports: clk, rst (async, active-high); i_start/i_op/i_a/i_b issue from EX;
//        i_hi_we/i_lo_we/i_wdata for MTHI/MTLO; i_abort flush;
//        o_stall (combinational freeze), o_busy, o_done (one-cycle pulse), o_hi, o_lo.
module hilo_muldiv_seq
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_abort,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW    = 2 * WIDTH;

    // Negate a single-width value through the shared double-width helper.
    function automatic logic [WIDTH-1:0] negw(input logic [WIDTH-1:0] x);
        return WIDTH'(neg2c(CPU_DWIDTH'(x)));
    endfunction

    muldiv_state_t    r_state;
    muldiv_state_t    w_next_state;
    muldiv_op_t       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_load;
    logic             w_step;
    logic             w_wb;
    muldiv_op_t       w_op;
    logic             w_is_div;
    logic             w_signed;
    logic             w_dbz;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic             w_core_div;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic [DW-1:0]    w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    // Issue decode; divide-by-zero keeps the raw dividend so it can be returned in HI.
    always_comb begin
        w_op     = muldiv_op_t'(i_op);
        w_is_div = (w_op == DIV) || (w_op == DIVU);
        w_signed = (w_op == MULT) || (w_op == DIV);
        w_dbz    = w_is_div && (i_b == '0);
        w_a_in   = (w_signed && i_a[WIDTH-1] && !w_dbz) ? negw(i_a) : i_a;
        w_b_in   = (w_signed && i_b[WIDTH-1]) ? negw(i_b) : i_b;
    end

    // Next-state and control strobes; abort overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_wb         = 1'b0;
        if (i_abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_load       = 1'b1;
                        w_next_state = w_dbz ? FIX : CALC;
                    end
                end
                CALC: begin
                    w_step = 1'b1;
                    if (r_cnt == '0) w_next_state = FIX;
                end
                FIX: begin
                    w_wb         = 1'b1;
                    w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    assign w_core_div = (r_op == DIV) || (r_op == DIVU);

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (w_core_div),
        .i_a      (w_a_in),
        .i_b      (w_b_in),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    // Sign correction and result routing for the writeback cycle.
    always_comb begin
        w_prod   = {w_core_hi, w_core_lo};
        w_res_hi = w_core_hi;
        w_res_lo = w_core_lo;
        if (r_dbz) begin
            w_res_hi = w_core_lo;
            w_res_lo = '1;
        end else if (w_core_div) begin
            w_res_hi = r_neg_r ? negw(w_core_hi) : w_core_hi;
            w_res_lo = r_neg_q ? negw(w_core_lo) : w_core_lo;
        end else begin
            if (r_neg_q) w_prod = DW'(neg2c(CPU_DWIDTH'(w_prod)));
            w_res_hi = w_prod[DW-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    // State, counter, sign flags and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= MULT;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_wb;
            if (w_load) begin
                r_op    <= w_op;
                r_cnt   <= CNT_W'(WIDTH - 1);
                r_neg_q <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                r_neg_r <= w_signed && w_is_div && i_a[WIDTH-1];
                r_dbz   <= w_dbz;
            end else if (w_step && (r_cnt != '0)) begin
                r_cnt   <= r_cnt - CNT_W'(1);
            end
            if (w_wb) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if ((r_state == IDLE) && !i_abort) begin
                if (i_hi_we) r_hi <= i_wdata;
                if (i_lo_we) r_lo <= i_wdata;
            end
        end
    end

    assign o_busy  = (r_state != IDLE);
    // Combinational so the issuing cycle is already frozen.
    assign o_stall = !rst && (o_busy || i_start);
    assign o_done  = r_done;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;

    // EX is frozen while busy, so a new issue must never arrive then.
    a_no_start_when_busy: assert property (
        @(posedge clk) disable iff (rst) !(i_start && (r_state != IDLE))
    );

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Purpose: self-checking bench for hilo_muldiv_seq using an expected-result queue.
// Drives at the falling edge, samples 1 time unit later.
module tb_hilo_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_hi_we;
    logic        i_lo_we;
    logic [31:0] i_wdata;
    logic        i_abort;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] sb[$];

    hilo_muldiv_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_hi_we (i_hi_we),
        .i_lo_we (i_lo_we),
        .i_wdata (i_wdata),
        .i_abort (i_abort),
        .o_stall (o_stall),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference {hi, lo} from native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sbv;
        longint q;
        longint r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            2'd0: return 64'(sa * sbv);
            2'd1: return {32'h0, a} * {32'h0, b};
            2'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one op, push its expectation, wait for done and compare.
    // hi_poke > 0 attempts an MTHI in that busy cycle, which must be ignored.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int hi_poke);
        logic [31:0] hi_prev;
        logic [63:0] e;
        bit          stall_ok;
        int          n;
        stall_ok = 1'b1;
        @(negedge clk);
        i_op = op; i_a = a; i_b = b; i_start = 1'b1;
        #1;
        chk("stall_issue", 64'(o_stall), 64'(1));
        sb.push_back(exp);
        hi_prev = o_hi;
        for (n = 1; n <= 100; n++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_hi_we = (n == hi_poke);
            i_wdata = 32'hDEAD_BEEF;
            #1;
            if ((hi_poke > 0) && (n == hi_poke + 1)) chk("hi_we_busy", 64'(o_hi), 64'(hi_prev));
            if (o_done) break;
            if (!o_stall || !o_busy) stall_ok = 1'b0;
        end
        i_hi_we = 1'b0;
        chk("latency", 64'(n), 64'(lat));
        chk("stall_while_busy", 64'(stall_ok), 64'(1));
        chk("stall_at_done", 64'(o_stall), 64'(0));
        chk("busy_at_done", 64'(o_busy), 64'(0));
        chk("sb_size", 64'(sb.size()), 64'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hi", 64'(o_hi), 64'(e[63:32]));
            chk("lo", 64'(o_lo), 64'(e[31:0]));
        end
        @(negedge clk);
        #1;
        chk("done_pulse", 64'(o_done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; i_start = 1'b1; i_op = 2'd0; i_a = '0; i_b = '0;
        i_hi_we = 1'b0; i_lo_we = 1'b0; i_wdata = '0; i_abort = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 64'(o_stall), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_hi", 64'(o_hi), 64'(0));
        chk("rst_lo", 64'(o_lo), 64'(0));
        i_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 34, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 34, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0);
        run_op(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34, 0);
        run_op(2'd3, 32'h0000_1234, 32'h0000_0000, {32'h0000_1234, 32'hFFFF_FFFF}, 2, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 34, 0);

        // MTLO while idle.
        @(negedge clk);
        i_lo_we = 1'b1; i_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        i_lo_we = 1'b0;
        #1;
        chk("mtlo_lo", 64'(o_lo), 64'(32'hCAFE_F00D));
        chk("mtlo_hi", 64'(o_hi), 64'(0));
        chk("mtlo_done", 64'(o_done), 64'(0));

        // MTHI during CALC is dropped; op then writes hi=3, lo=0.
        run_op(2'd1, 32'h0001_0000, 32'h0003_0000, {32'h0000_0003, 32'h0000_0000}, 34, 5);

        // Abort mid-multiply.
        @(negedge clk);
        i_op = 2'd0; i_a = 32'd5; i_b = 32'd6; i_start = 1'b1;
        seen = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_abort = (n == 10);
        end
        @(negedge clk);
        i_abort = 1'b0;
        #1;
        chk("abort_busy", 64'(o_busy), 64'(0));
        chk("abort_stall", 64'(o_stall), 64'(0));
        chk("abort_hi", 64'(o_hi), 64'(3));
        chk("abort_lo", 64'(o_lo), 64'(0));
        for (int n = 0; n < 40; n++) begin
            if (o_done) seen = 1'b1;
            @(negedge clk);
            #1;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        run_op(2'd0, 32'd5, 32'd6, {32'd0, 32'd30}, 34, 0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        i_op = 2'd2; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hi", 64'(o_hi), 64'(0));
        chk("arst_lo", 64'(o_lo), 64'(0));
        chk("arst_busy", 64'(o_busy), 64'(0));
        chk("arst_stall", 64'(o_stall), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        run_op(2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 0);

        // Random ops against the arithmetic model.
        for (int k = 0; k < 6; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (k == 5) ? 32'h0 : $urandom;
            run_op(rop, ra, rb, model(rop, ra, rb), (rop[1] && (rb == 32'h0)) ? 2 : 34, 0);
        end

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_seq.md
Name: hilo_muldiv_seq

Overview:
- Multi-cycle sequencer for the MIPS HI/LO multiply/divide resource.
- Owns the architectural HI and LO registers.
- Accepts MULT/MULTU/DIV/DIVU issues from the execute stage and iterates a shift-add or restoring-divide datapath over WIDTH cycles.
- Drives a stall to freeze FETCH/EX while busy; also services MTHI/MTLO writes.

Parameters:
WIDTH  32  operand and HI/LO width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  issue request from EX (one-cycle qualifier)
op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
a  in  WIDTH  rs operand (multiplicand/dividend)
b  in  WIDTH  rt operand (multiplier/divisor)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO data
abort  in  1  flush: cancel operation in flight
stall  out  1  freeze FETCH/EX
busy  out  1  operation in flight
done  out  1  one-cycle pulse when HI/LO are updated by an op
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0. stall=0 while rst.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 and b!=0 (or op is MULT/MULTU): latch |a|, |b| for signed ops, raw operands for unsigned ops. Latch result-sign flags and op. Counter=WIDTH-1. Go to CALC.
  - start=1, op=DIV/DIVU, b==0: go directly to FIX with forced result hi=a, lo=all-ones.
- CALC:
  - One iteration per cycle.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - After the iteration with counter==0, go to FIX; otherwise decrement counter.
- FIX:
  - Apply sign correction and write hi/lo; done=1 for exactly this edge's following cycle; go to IDLE.
  - Signed multiply: negate the 2*WIDTH product if sign(a)!=sign(b).
  - Signed divide: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Divide results: quotient->lo, remainder->hi. Multiply results: product[2W-1:W]->hi, product[W-1:0]->lo.
- Latency: start sampled at edge T0. CALC occupies edges T1..T32 (WIDTH=32). hi/lo written and done asserted after edge T33. Divide-by-zero: written after edge T1.
- Output timing:
  - busy = (state!=IDLE), registered-state derived.
  - stall = busy | start, combinational, so the issuing cycle is already frozen.
  - stall deasserts in the cycle done is high.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (modular negate); no exception.
- start while busy: ignored (EX is stalled; must not occur). Assertion flags it.
- hi_we/lo_we:
  - In IDLE with no start: register updated at next edge; done stays 0.
  - While busy: ignored.
  - In IDLE with start in the same cycle: write applied, later overwritten at FIX.
- abort: any state -> IDLE at next edge. hi/lo unchanged, done=0, busy=0. abort has priority over start and over FIX writeback.
- Async rst mid-operation: immediate return to reset values; no partial HI/LO update.

Decomposition:
- Shared package cpu_pkg:
  - muldiv_op_t enum (MULT, MULTU, DIV, DIVU).
  - muldiv_state_t enum (IDLE, CALC, FIX).
  - Constant MULDIV_ITERS = WIDTH.
  - Function neg2c for two's-complement negate.
- One sub-module is natural: muldiv_core, holding the iterative accumulator/remainder datapath and controlled by FSM strobes. The FSM, HI/LO registers and stall logic stay in hilo_muldiv_seq.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high for cycles 0..33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x00001234, b=0 -> done 2 cycles after start, hi=0x00001234, lo=0xFFFFFFFF; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Idle lo_we=1, wdata=0xCAFEF00D -> lo=0xCAFEF00D next cycle, done=0. hi_we asserted during CALC -> hi unchanged.
- MULT 5×6 with abort at cycle 10 -> busy/stall low next cycle, hi/lo retain the prior values, no done pulse. Then MULT 5×6 completes with lo=30, hi=0.
- Async rst asserted mid-DIV at cycle 20 -> hi=lo=0, busy=0, stall=0 immediately. After release, a new DIVU 100/7 gives lo=14, hi=2.
